// File: rtl/bar_level_ctrl.sv
// Audio bar meter: windowed peak amplitude to thermometer level, with peak-hold marker and theme select.
// Outputs update one cycle after frame_start (two after the frame boundary); no backpressure, every sample_valid is consumed.
module bar_level_ctrl #(
  parameter int WINDOW      = 4000,
  parameter int HOLD_FRAMES = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] mic_in,
  input  logic [12:0] pixel_index,
  input  logic        SW_12,
  input  logic        SW_11,
  output logic [15:0] led_light,
  output logic [4:0]  peak_level,
  output logic [1:0]  theme,
  output logic        frame_start
);

  logic [15:0] win_cnt;
  logic [10:0] win_peak;
  logic [10:0] amp;
  logic [10:0] win_max;
  logic [4:0]  win_level;
  logic [4:0]  pending;
  logic [4:0]  snap;
  logic [7:0]  hold_cnt;
  logic [12:0] pix_prev;
  logic [1:0]  sw_meta;
  logic [1:0]  sw_sync;
  logic        frame_bnd;
  logic        win_last;
  logic [16:0] therm;

  always_comb begin
    // Above midscale the amplitude is simply the low 11 bits.
    amp       = mic_in[11] ? mic_in[10:0] : 11'd0;
    win_max   = (amp > win_peak) ? amp : win_peak;
    win_level = (win_max == 11'd0) ? 5'd0 : ({1'b0, win_max[10:7]} + 5'd1);
    win_last  = (win_cnt == 16'(WINDOW - 1));
    frame_bnd = (pixel_index == 13'd0) && (pix_prev != 13'd0);
    therm     = (17'd1 << snap) - 17'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_cnt     <= '0;
      win_peak    <= '0;
      pending     <= '0;
      snap        <= '0;
      hold_cnt    <= '0;
      pix_prev    <= '0;
      sw_meta     <= '0;
      sw_sync     <= '0;
      led_light   <= '0;
      peak_level  <= '0;
      theme       <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_prev    <= pixel_index;
      sw_meta     <= {SW_12, SW_11};
      sw_sync     <= sw_meta;
      frame_start <= frame_bnd;

      // Capture the level before any window finishing this cycle can overwrite it.
      if (frame_bnd)
        snap <= pending;

      if (sample_valid) begin
        if (win_last) begin
          pending  <= win_level;
          win_peak <= '0;
          win_cnt  <= '0;
        end else begin
          win_peak <= win_max;
          win_cnt  <= win_cnt + 16'd1;
        end
      end

      if (frame_start) begin
        led_light <= therm[15:0];
        theme     <= sw_sync[1] ? 2'd2 : (sw_sync[0] ? 2'd1 : 2'd0);
        if (snap >= peak_level) begin
          peak_level <= snap;
          hold_cnt   <= 8'(HOLD_FRAMES);
        end else if (hold_cnt != 8'd0) begin
          hold_cnt <= hold_cnt - 8'd1;
        end else begin
          peak_level <= peak_level - 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bar_level_ctrl.sv
// Directed bench for bar_level_ctrl with WINDOW=4, HOLD_FRAMES=3: a queue-based reference model
// compared every cycle, plus literal expectations at the interesting points.
module tb_bar_level_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] mic_in;
  logic [12:0] pixel_index;
  logic        SW_12;
  logic        SW_11;
  logic [15:0] led_light;
  logic [4:0]  peak_level;
  logic [1:0]  theme;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  bar_level_ctrl #(.WINDOW(4), .HOLD_FRAMES(3)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid), .mic_in(mic_in),
    .pixel_index(pixel_index), .SW_12(SW_12), .SW_11(SW_11),
    .led_light(led_light), .peak_level(peak_level), .theme(theme), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples collected in a queue, a window is its max once it holds 4 entries.
  int  amps[$];
  int  m_pending, m_snap, m_led, m_peak, m_hold, m_theme, m_prev_pix, mx, lvl;
  bit  m_fs, m_valid, bnd;
  int  sw_h1, sw_h2;

  always @(posedge clock) begin
    if (reset) begin
      amps.delete();
      m_pending = 0; m_snap = 0; m_led = 0; m_peak = 0; m_hold = 0; m_theme = 0;
      m_fs = 0; m_prev_pix = 0; sw_h1 = 0; sw_h2 = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_fs) begin
        m_led   = ((1 << m_snap) - 1) & 16'hFFFF;
        m_theme = (sw_h2 >= 2) ? 2 : (sw_h2 == 1 ? 1 : 0);
        if (m_snap >= m_peak) begin
          m_peak = m_snap;
          m_hold = 3;
        end else if (m_hold > 0) begin
          m_hold = m_hold - 1;
        end else begin
          m_peak = (m_peak - 1 < m_snap) ? m_snap : m_peak - 1;
        end
      end
      bnd = (pixel_index == 0) && (m_prev_pix != 0);
      if (bnd) m_snap = m_pending;
      if (sample_valid) begin
        amps.push_back((int'(mic_in) >= 2048) ? int'(mic_in) - 2048 : 0);
        if (amps.size() == 4) begin
          mx = 0;
          foreach (amps[i]) if (amps[i] > mx) mx = amps[i];
          m_pending = (mx == 0) ? 0 : mx / 128 + 1;
          amps.delete();
        end
      end
      m_fs       = bnd;
      sw_h2      = sw_h1;
      sw_h1      = SW_12 * 2 + SW_11;
      m_prev_pix = int'(pixel_index);
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_led_light", int'(led_light), m_led);
      chk("model_peak_level", int'(peak_level), m_peak);
      chk("model_theme", int'(theme), m_theme);
      chk("model_frame_start", int'(frame_start), int'(m_fs));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sample(input int v);
    sample_valid = 1'b1;
    mic_in       = 12'(v);
    tick();
    sample_valid = 1'b0;
    mic_in       = 12'd0;
    tick();
  endtask

  // Boundary cycle, then wait until the frame_start update has landed.
  task automatic frame();
    pixel_index = 13'd0;
    tick();
    pixel_index = 13'd7;
    tick(3);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    @(negedge clock);
    chk(name, act, exp);
  endtask

  int exp_peaks[10] = '{8, 8, 8, 7, 6, 5, 4, 3, 2, 2};

  initial begin
    m_valid = 0;
    reset = 1'b1; sample_valid = 1'b0; mic_in = '0; pixel_index = '0; SW_12 = 1'b0; SW_11 = 1'b0;
    tick(3);
    @(negedge clock);
    chk("reset_led", int'(led_light), 0);
    chk("reset_peak", int'(peak_level), 0);
    chk("reset_theme", int'(theme), 0);
    chk("reset_fs", int'(frame_start), 0);
    reset = 1'b0;
    pixel_index = 13'd7;
    tick(2);

    sample(2048); sample(2100); sample(3000); sample(2200);
    frame();
    lit("basic_led", int'(led_light), 16'h00FF);
    lit("basic_peak", int'(peak_level), 8);

    sample(2048); sample(4095); sample(100); sample(2300);
    frame();
    lit("full_led", int'(led_light), 16'hFFFF);
    lit("full_peak", int'(peak_level), 16);

    sample(2048); sample(0); sample(1000); sample(2048);
    frame();
    lit("silent_led", int'(led_light), 0);
    lit("silent_peak_held", int'(peak_level), 16);

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    pixel_index = 13'd7;
    tick(2);
    sample(2048); sample(3000); sample(2100); sample(2048);
    frame();
    lit("decay_start", int'(peak_level), 8);
    sample(2248); sample(2048); sample(2048); sample(2100);
    for (int f = 0; f < 10; f++) begin
      frame();
      lit($sformatf("decay_frame%0d", f), int'(peak_level), exp_peaks[f]);
    end
    lit("decay_led", int'(led_light), 16'h0003);

    sample(4095); sample(4095); sample(4095);
    sample_valid = 1'b1; mic_in = 12'd4095; pixel_index = 13'd0;
    tick();
    sample_valid = 1'b0; mic_in = '0; pixel_index = 13'd7;
    tick(3);
    lit("coincident_old_led", int'(led_light), 16'h0003);
    frame();
    lit("coincident_new_led", int'(led_light), 16'hFFFF);

    SW_11 = 1'b1; SW_12 = 1'b1;
    tick(4);
    lit("theme_held", int'(theme), 0);
    frame();
    lit("theme_sw12", int'(theme), 2);
    SW_12 = 1'b0;
    tick(4);
    lit("theme_held2", int'(theme), 2);
    frame();
    lit("theme_sw11", int'(theme), 1);

    sample(2048); sample(4095);
    pixel_index = 13'd0; reset = 1'b1;
    tick();
    lit("reset_kills_fs", int'(frame_start), 0);
    reset = 1'b0;
    pixel_index = 13'd7;
    tick(2);
    sample(2048); sample(2048); sample(2048); sample(2048);
    frame();
    lit("reset_window_led", int'(led_light), 0);
    lit("reset_window_peak", int'(peak_level), 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
